cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
// MIPS CP0 register file sitting directly downstream of the exception classifier. Takes the
// resolved excepttype code from the MEM stage and commits the architectural side effects:
// EPC/Cause/Status/BadVAddr updates and the eret return. It also supplies MFC0 reads, accepts
// MTC0 writes, and runs the Count/Compare timer whose interrupt feeds back into Cause.IP.
// PARAMETERS
// PRID_VAL   32'h0000_4220  value returned for PRId (reg 15), read-only
// CONFIG_VAL 32'h0000_8000  value returned for Config (reg 16), read-only
// PORTS
// clk            in   1   clock, all state updates on rising edge
// rst            in   1   synchronous reset, active-high
// we_i           in   1   MTC0 write enable
// waddr_i        in   5   MTC0 destination register number
// raddr_i        in   5   MFC0 source register number
// data_i         in   32  MTC0 write data
// int_i          in   6   external hardware interrupt lines (level)
// excepttype_i   in   32  classified exception code (0 = none)
// pc_i           in   32  PC of the instruction in MEM
// is_delayslot_i in   1   MEM instruction is in a branch delay slot
// bad_addr_i     in   32  faulting address for AdEL/AdES
// data_o         out  32  MFC0 read data (combinational)
// badvaddr_o / count_o / compare_o / status_o / cause_o / epc_o  out 32  register contents
// timer_int_o    out  1   Count==Compare timer interrupt pending
// BEHAVIOUR
// - Reset: badvaddr=0, count=0, compare=0, status=32'h0040_0000 (BEV=1), cause=0, epc=0,
//   timer_int_o=0, internal count toggle=0.
// - Count: increments by 1 every second cycle (internal toggle bit); wraps 32'hFFFF_FFFF->0.
// - Timer: compare!=0 and count==compare -> timer_int_o<=1 next edge, sticky until an MTC0 to
//   Compare (reg 11), which clears it in the same edge as the write.
// - Cause.IP[7:2] (bits 15:10) <= {int_i[5]|timer_int_o, int_i[4:0]} every cycle, not writable.
// - MTC0 (we_i, no exception this cycle): 9 Count full; 11 Compare full; 12 Status full;
//   13 Cause only IP[1:0] (bits 9:8); 14 EPC full; 8/15/16 and unlisted addresses ignored.
// - Exception (excepttype_i != 0) takes priority; a same-cycle MTC0 is dropped:
//   codes 0x1->ExcCode 0, 0x4->4, 0x5->5, 0x8->8, 0x9->9, 0xa->10, 0xc->12.
//   If Status.EXL==0: epc<=is_delayslot_i ? pc_i-4 : pc_i; Cause.BD(31)<=is_delayslot_i.
//   If Status.EXL==1: epc and BD unchanged (nested). Always Status.EXL(1)<=1, Cause[6:2]<=ExcCode.
//   0x4/0x5 additionally badvaddr<=bad_addr_i.
// - 0xe (eret): Status.EXL<=0 only; no other register changes.
// - Any other nonzero code: ignored (no state change, MTC0 still dropped).
// - Read: data_o = register at raddr_i; unimplemented addresses read 0. Bypass: if we_i and
//   waddr_i==raddr_i with no exception, data_o returns the write-masked new value.
// - Count write and increment same cycle: the write wins.
// - rst asserted mid-exception: reset values win, the exception is lost.
// TESTING
// - Reset then idle 10 cycles -> count==5, status==32'h0040_0000, timer_int_o==0.
// - MTC0 compare=8 -> timer_int_o rises when count reaches 8, stays 1; MTC0 compare=100 -> 0.
// - excepttype 0x8, pc=0xBFC0_0100, delayslot=1, EXL=0 -> epc=0xBFC0_00FC, BD=1, ExcCode=8, EXL=1.
// - excepttype 0x4 with EXL already 1, bad_addr=0x1003 -> epc unchanged, badvaddr=0x1003, ExcCode=4.
// - excepttype 0xe -> EXL=0 only; same-cycle MTC0 epc=0x1234 with excepttype 0xc -> epc not 0x1234.
// - MTC0 cause=0xFFFF_FFFF, int_i=6'b000001 -> cause[9:8]=2'b11, cause[10]=1, other bits 0;
//   MFC0 of reg 13 in the write cycle returns the masked value.

Source files
------------

// File: rtl/cp0_regfile.sv
// CP0 register file: exception commit, eret, MFC0/MTC0 access and the
// Count/Compare timer whose interrupt is folded back into Cause.IP7.
module cp0_regfile #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        is_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    typedef enum logic [4:0] {
        REG_BADVADDR = 5'd8,
        REG_COUNT    = 5'd9,
        REG_COMPARE  = 5'd11,
        REG_STATUS   = 5'd12,
        REG_CAUSE    = 5'd13,
        REG_EPC      = 5'd14,
        REG_PRID     = 5'd15,
        REG_CONFIG   = 5'd16
    } cp0_reg_e;

    typedef enum logic [31:0] {
        EXC_INT  = 32'h0000_0001,
        EXC_ADEL = 32'h0000_0004,
        EXC_ADES = 32'h0000_0005,
        EXC_SYS  = 32'h0000_0008,
        EXC_BP   = 32'h0000_0009,
        EXC_RI   = 32'h0000_000a,
        EXC_OV   = 32'h0000_000c,
        EXC_ERET = 32'h0000_000e
    } exc_e;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    logic [31:0] badvaddr_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic [31:0] status_r;
    logic [31:0] cause_r;
    logic [31:0] epc_r;
    logic        timer_int_r;
    logic        tick_r;

    logic        exc_any;
    logic        exc_take;
    logic        exc_badaddr;
    logic        exc_eret;
    logic [4:0]  exc_code;
    logic        mtc0_ok;

    // Decode the classified exception code into the action to commit.
    always_comb begin
        exc_take    = 1'b0;
        exc_badaddr = 1'b0;
        exc_eret    = 1'b0;
        exc_code    = '0;
        exc_any     = |excepttype_i;
        case (excepttype_i)
            EXC_INT:  begin exc_take = 1'b1; exc_code = 5'd0;  end
            EXC_ADEL: begin exc_take = 1'b1; exc_code = 5'd4;  exc_badaddr = 1'b1; end
            EXC_ADES: begin exc_take = 1'b1; exc_code = 5'd5;  exc_badaddr = 1'b1; end
            EXC_SYS:  begin exc_take = 1'b1; exc_code = 5'd8;  end
            EXC_BP:   begin exc_take = 1'b1; exc_code = 5'd9;  end
            EXC_RI:   begin exc_take = 1'b1; exc_code = 5'd10; end
            EXC_OV:   begin exc_take = 1'b1; exc_code = 5'd12; end
            EXC_ERET: exc_eret = 1'b1;
            default:  ;
        endcase
        // Any nonzero code, even an unrecognised one, drops the MTC0.
        mtc0_ok = we_i & ~exc_any;
    end

    // Count/Compare timer: count advances every second cycle, a write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= '0;
            compare_r   <= '0;
            timer_int_r <= 1'b0;
            tick_r      <= 1'b0;
        end else begin
            tick_r <= ~tick_r;
            if (mtc0_ok && waddr_i == REG_COUNT)
                count_r <= data_i;
            else if (tick_r)
                count_r <= count_r + 32'd1;
            if (mtc0_ok && waddr_i == REG_COMPARE) begin
                compare_r   <= data_i;
                timer_int_r <= 1'b0;
            end else if (compare_r != '0 && count_r == compare_r) begin
                timer_int_r <= 1'b1;
            end
        end
    end

    // Exception/eret commit and MTC0 writes to Status, Cause, EPC, BadVAddr.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_r <= '0;
            status_r   <= STATUS_RST;
            cause_r    <= '0;
            epc_r      <= '0;
        end else begin
            cause_r[15:10] <= {int_i[5] | timer_int_r, int_i[4:0]};
            if (exc_take) begin
                if (!status_r[1]) begin
                    epc_r       <= is_delayslot_i ? pc_i - 32'd4 : pc_i;
                    cause_r[31] <= is_delayslot_i;
                end
                status_r[1]  <= 1'b1;
                cause_r[6:2] <= exc_code;
                if (exc_badaddr)
                    badvaddr_r <= bad_addr_i;
            end else if (exc_eret) begin
                status_r[1] <= 1'b0;
            end else if (mtc0_ok) begin
                case (waddr_i)
                    REG_STATUS: status_r      <= data_i;
                    REG_CAUSE:  cause_r[9:8]  <= data_i[9:8];
                    REG_EPC:    epc_r         <= data_i;
                    default:    ;
                endcase
            end
        end
    end

    // MFC0 read mux with bypass of a same-cycle accepted MTC0 to the same register.
    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_r;
            REG_COUNT:    data_o = count_r;
            REG_COMPARE:  data_o = compare_r;
            REG_STATUS:   data_o = status_r;
            REG_CAUSE:    data_o = cause_r;
            REG_EPC:      data_o = epc_r;
            REG_PRID:     data_o = PRID_VAL;
            REG_CONFIG:   data_o = CONFIG_VAL;
            default:      data_o = '0;
        endcase
        if (mtc0_ok && waddr_i == raddr_i) begin
            case (waddr_i)
                REG_COUNT:   data_o = data_i;
                REG_COMPARE: data_o = data_i;
                REG_STATUS:  data_o = data_i;
                REG_CAUSE:   data_o = {cause_r[31:10], data_i[9:8], cause_r[7:0]};
                REG_EPC:     data_o = data_i;
                default:     ;
            endcase
        end
    end

    assign badvaddr_o  = badvaddr_r;
    assign count_o     = count_r;
    assign compare_o   = compare_r;
    assign status_o    = status_r;
    assign cause_o     = cause_r;
    assign epc_o       = epc_r;
    assign timer_int_o = timer_int_r;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, timer, exceptions, eret, MTC0/MFC0.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        is_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] badvaddr_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    cp0_regfile #(
        .PRID_VAL   (32'h0000_4220),
        .CONFIG_VAL (32'h0000_8000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .raddr_i        (raddr_i),
        .data_i         (data_i),
        .int_i          (int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .is_delayslot_i (is_delayslot_i),
        .bad_addr_i     (bad_addr_i),
        .data_o         (data_o),
        .badvaddr_o     (badvaddr_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .timer_int_o    (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return at the following falling edge.
    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = '0; data_i = '0;
        excepttype_i = '0; pc_i = '0; is_delayslot_i = 1'b0; bad_addr_i = '0;
    endtask

    initial begin
        rst = 1'b1; raddr_i = '0; int_i = '0;
        idle_inputs();
        step(2);
        check_val("rst_count",    count_o,    32'h0);
        check_val("rst_compare",  compare_o,  32'h0);
        check_val("rst_status",   status_o,   32'h0040_0000);
        check_val("rst_cause",    cause_o,    32'h0);
        check_val("rst_epc",      epc_o,      32'h0);
        check_val("rst_badvaddr", badvaddr_o, 32'h0);
        check_val("rst_timer",    {31'b0, timer_int_o}, 32'h0);
        raddr_i = 5'd15; #1 check_val("rd_prid",   data_o, 32'h0000_4220);
        raddr_i = 5'd16; #1 check_val("rd_config", data_o, 32'h0000_8000);
        raddr_i = 5'd10; #1 check_val("rd_unimpl", data_o, 32'h0);
        rst = 1'b0;

        step(10);
        check_val("idle_count",  count_o,  32'd5);
        check_val("idle_status", status_o, 32'h0040_0000);
        check_val("idle_timer",  {31'b0, timer_int_o}, 32'h0);

        // Compare = 8; count sits at 5 with the toggle low.
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd8;
        step(1);
        idle_inputs();
        check_val("cmp_written", compare_o, 32'd8);
        step(5);
        check_val("cnt_at_8",     count_o, 32'd8);
        check_val("timer_before", {31'b0, timer_int_o}, 32'h0);
        step(1);
        check_val("timer_rise",   {31'b0, timer_int_o}, 32'h1);
        step(1);
        check_val("timer_sticky", {31'b0, timer_int_o}, 32'h1);
        check_val("cause_ip7",    {31'b0, cause_o[15]}, 32'h1);
        check_val("cnt_at_9",     count_o, 32'd9);
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd100;
        step(1);
        idle_inputs();
        check_val("timer_clear",  {31'b0, timer_int_o}, 32'h0);

        // Syscall in a delay slot with EXL clear; the MTC0 to EPC is dropped.
        excepttype_i = 32'h8; pc_i = 32'hBFC0_0100; is_delayslot_i = 1'b1;
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h0000_DEAD;
        step(1);
        idle_inputs();
        check_val("sys_epc",     epc_o, 32'hBFC0_00FC);
        check_val("sys_bd",      {31'b0, cause_o[31]}, 32'h1);
        check_val("sys_exccode", {27'b0, cause_o[6:2]}, 32'd8);
        check_val("sys_status",  status_o, 32'h0040_0002);

        // Nested AdEL with EXL already set.
        excepttype_i = 32'h4; pc_i = 32'h0000_5000; bad_addr_i = 32'h0000_1003;
        step(1);
        idle_inputs();
        check_val("adel_epc",      epc_o, 32'hBFC0_00FC);
        check_val("adel_badvaddr", badvaddr_o, 32'h0000_1003);
        check_val("adel_exccode",  {27'b0, cause_o[6:2]}, 32'd4);
        check_val("adel_bd",       {31'b0, cause_o[31]}, 32'h1);

        excepttype_i = 32'he;
        step(1);
        idle_inputs();
        check_val("eret_status",  status_o, 32'h0040_0000);
        check_val("eret_epc",     epc_o, 32'hBFC0_00FC);
        check_val("eret_exccode", {27'b0, cause_o[6:2]}, 32'd4);

        // Overflow with a competing MTC0 to EPC.
        excepttype_i = 32'hc; pc_i = 32'h0000_2000;
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h0000_1234;
        step(1);
        idle_inputs();
        check_val("ov_epc",     epc_o, 32'h0000_2000);
        check_val("ov_exccode", {27'b0, cause_o[6:2]}, 32'd12);
        check_val("ov_bd",      {31'b0, cause_o[31]}, 32'h0);

        // Unrecognised code: no change, MTC0 to Status dropped.
        excepttype_i = 32'h3; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
        step(1);
        idle_inputs();
        check_val("unk_status",  status_o, 32'h0040_0002);
        check_val("unk_exccode", {27'b0, cause_o[6:2]}, 32'd12);

        excepttype_i = 32'he;
        step(1);
        idle_inputs();

        // Plain MTC0 EPC with read bypass.
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h0000_1234; raddr_i = 5'd14;
        #1 check_val("epc_bypass", data_o, 32'h0000_1234);
        step(1);
        idle_inputs();
        check_val("epc_write", epc_o, 32'h0000_1234);

        // Reset arriving together with an exception.
        rst = 1'b1; excepttype_i = 32'h8; pc_i = 32'h0000_4000;
        step(1);
        rst = 1'b0; idle_inputs();
        check_val("rstx_status", status_o, 32'h0040_0000);
        check_val("rstx_epc",    epc_o, 32'h0);
        check_val("rstx_cause",  cause_o, 32'h0);

        int_i = 6'b000001;
        step(1);
        check_val("int_ip2", cause_o, 32'h0000_0400);
        we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hFFFF_FFFF; raddr_i = 5'd13;
        #1 check_val("cause_bypass", data_o, 32'h0000_0700);
        step(1);
        idle_inputs();
        check_val("cause_write", cause_o, 32'h0000_0700);

        // Read-only PRId ignores writes.
        we_i = 1'b1; waddr_i = 5'd15; data_i = 32'h0; raddr_i = 5'd15;
        #1 check_val("prid_nobypass", data_o, 32'h0000_4220);
        step(1);
        idle_inputs();
        check_val("prid_keep", data_o, 32'h0000_4220);

        // Count write on an increment cycle wins, then wraps to zero.
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFF_FFFF; raddr_i = 5'd9;
        #1 check_val("cnt_bypass", data_o, 32'hFFFF_FFFF);
        step(1);
        idle_inputs();
        check_val("cnt_write_wins", count_o, 32'hFFFF_FFFF);
        step(2);
        check_val("cnt_wrap", count_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
